// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the writeback path: default widths, load funct3 codes
// and writeback-unit state encoding.
package ysyx_22050019_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned ADDR_WIDTH_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef logic [0:0] wbu_state_t;
    localparam wbu_state_t ST_IDLE      = 1'b0;
    localparam wbu_state_t ST_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/ysyx_22050019_load_ext.sv
// Aligns a raw 8-byte LSU doubleword by the load offset and sign/zero-extends
// it by funct3; funct3=111 is flagged illegal and passed through as a doubleword.
module ysyx_22050019_load_ext
    import ysyx_22050019_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_data,
    output logic        o_illegal
);

    logic [63:0] w_shifted;

    // Bytes shifted in from above the doubleword read as zero.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_data    = w_shifted;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_LB:   o_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   o_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   o_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_LD:   o_data = w_shifted;
            F3_LBU:  o_data = {56'd0, w_shifted[7:0]};
            F3_LHU:  o_data = {48'd0, w_shifted[15:0]};
            F3_LWU:  o_data = {32'd0, w_shifted[31:0]};
            default: begin
                o_data    = w_shifted;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22050019_wbu.sv
// Writeback unit: retires EXU results (or LSU load data) into the register file
// and emits one commit pulse per instruction for difftest.
module ysyx_22050019_wbu
    import ysyx_22050019_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [2:0]            in_addr_lo,
    input  logic                  lsu_rvalid,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic                  busy_valid,
    output logic [ADDR_WIDTH-1:0] busy_rd,
    output logic [63:0]           retire_cnt,
    output logic                  err
);

    wbu_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_wen;
    logic [2:0]            r_funct3;
    logic [2:0]            r_addr_lo;

    wbu_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_nxt;
    logic                  w_wen_nxt;
    logic [2:0]            w_funct3_nxt;
    logic [2:0]            w_addr_lo_nxt;
    logic                  w_rf_wen_nxt;
    logic [ADDR_WIDTH-1:0] w_rf_waddr_nxt;
    logic [DATA_WIDTH-1:0] w_rf_wdata_nxt;
    logic                  w_commit_valid_nxt;
    logic [DATA_WIDTH-1:0] w_commit_pc_nxt;
    logic                  w_busy_valid_nxt;
    logic [ADDR_WIDTH-1:0] w_busy_rd_nxt;
    logic [63:0]           w_retire_cnt_nxt;
    logic                  w_err_nxt;

    logic [63:0]           w_ext_data;
    logic                  w_ext_illegal;

    assign in_ready = (r_state == ST_IDLE);

    ysyx_22050019_load_ext u_load_ext (
        .i_rdata   (64'(lsu_rdata)),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_ext_data),
        .o_illegal (w_ext_illegal)
    );

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_rd_nxt           = r_rd;
        w_wen_nxt          = r_wen;
        w_funct3_nxt       = r_funct3;
        w_addr_lo_nxt      = r_addr_lo;
        w_rf_wen_nxt       = 1'b0;
        w_rf_waddr_nxt     = rf_waddr;
        w_rf_wdata_nxt     = rf_wdata;
        w_commit_valid_nxt = 1'b0;
        w_commit_pc_nxt    = commit_pc;
        w_busy_valid_nxt   = busy_valid;
        w_busy_rd_nxt      = busy_rd;
        w_retire_cnt_nxt   = retire_cnt;
        w_err_nxt          = err;

        case (r_state)
            ST_IDLE: begin
                // Read data with no load outstanding is a protocol error.
                if (lsu_rvalid) begin
                    w_err_nxt = 1'b1;
                end
                if (in_valid) begin
                    if (in_is_load) begin
                        w_pc_nxt         = in_pc;
                        w_rd_nxt         = in_rd;
                        w_wen_nxt        = in_wen;
                        w_funct3_nxt     = in_funct3;
                        w_addr_lo_nxt    = in_addr_lo;
                        w_busy_valid_nxt = 1'b1;
                        w_busy_rd_nxt    = (in_wen && (in_rd != '0)) ? in_rd : '0;
                        w_state_nxt      = ST_WAIT_LOAD;
                    end else begin
                        w_rf_wen_nxt       = in_wen && (in_rd != '0);
                        w_rf_waddr_nxt     = in_rd;
                        w_rf_wdata_nxt     = in_data;
                        w_commit_valid_nxt = 1'b1;
                        w_commit_pc_nxt    = in_pc;
                        w_retire_cnt_nxt   = retire_cnt + 64'd1;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (lsu_rvalid) begin
                    w_rf_wen_nxt       = r_wen && (r_rd != '0);
                    w_rf_waddr_nxt     = r_rd;
                    w_rf_wdata_nxt     = DATA_WIDTH'(w_ext_data);
                    w_commit_valid_nxt = 1'b1;
                    w_commit_pc_nxt    = r_pc;
                    w_retire_cnt_nxt   = retire_cnt + 64'd1;
                    w_busy_valid_nxt   = 1'b0;
                    w_busy_rd_nxt      = '0;
                    w_err_nxt          = err | w_ext_illegal;
                    w_state_nxt        = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_rd         <= '0;
            r_wen        <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            busy_valid   <= 1'b0;
            busy_rd      <= '0;
            retire_cnt   <= '0;
            err          <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_rd         <= w_rd_nxt;
            r_wen        <= w_wen_nxt;
            r_funct3     <= w_funct3_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            rf_wen       <= w_rf_wen_nxt;
            rf_waddr     <= w_rf_waddr_nxt;
            rf_wdata     <= w_rf_wdata_nxt;
            commit_valid <= w_commit_valid_nxt;
            commit_pc    <= w_commit_pc_nxt;
            busy_valid   <= w_busy_valid_nxt;
            busy_rd      <= w_busy_rd_nxt;
            retire_cnt   <= w_retire_cnt_nxt;
            err          <= w_err_nxt;
        end
    end

endmodule
